// File: rtl/code_conv_arbiter.sv
// Round-robin front end for one shared combinational code converter: grants a
// requester, drives the converter from registers, and returns the result.
module code_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_code,
  input  logic [2*NUM_REQ-1:0] req_sel,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [3:0]           conv_code_in,
  output logic [1:0]           conv_select,
  input  logic [3:0]           conv_code_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [3:0]           rsp_code,
  output logic                 rsp_err,
  output logic [7:0]           done_count,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]         conv_code_in_q, conv_code_in_d;
  logic [1:0]         conv_select_q, conv_select_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [3:0]         rsp_code_q, rsp_code_d;
  logic               rsp_err_q, rsp_err_d;
  logic [7:0]         done_count_q, done_count_d;
  logic [7:0]         err_count_q, err_count_d;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [3:0]         win_code;
  logic [1:0]         win_sel;
  logic               err_now;

  // Two passes give the wrap-around search: indices above last first, then 0..last.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_code   = '0;
    win_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[i] && (i > int'(last_q))) begin
        win_found     = 1'b1;
        win_idx       = IDW'(i);
        win_onehot[i] = 1'b1;
        win_code      = req_code[4*i +: 4];
        win_sel       = req_sel[2*i +: 2];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[i] && (i <= int'(last_q))) begin
        win_found     = 1'b1;
        win_idx       = IDW'(i);
        win_onehot[i] = 1'b1;
        win_code      = req_code[4*i +: 4];
        win_sel       = req_sel[2*i +: 2];
      end
    end
  end

  always_comb begin
    unique case (conv_select_q)
      2'b01:   err_now = (conv_code_in_q > 4'd9);
      2'b11:   err_now = (conv_code_in_q < 4'd3) || (conv_code_in_q > 4'd12);
      default: err_now = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    gnt_d          = '0;
    conv_code_in_d = conv_code_in_q;
    conv_select_d  = conv_select_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_code_d     = rsp_code_q;
    rsp_err_d      = rsp_err_q;
    done_count_d   = done_count_q;
    err_count_d    = err_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_DRIVE;
          last_d         = win_idx;
          gnt_d          = win_onehot;
          conv_code_in_d = win_code;
          conv_select_d  = win_sel;
          rsp_id_d       = win_idx;
        end
      end
      S_DRIVE: begin
        state_d     = S_RESP;
        rsp_code_d  = conv_code_out;
        rsp_err_d   = err_now;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d      = S_IDLE;
          rsp_valid_d  = 1'b0;
          done_count_d = done_count_q + 8'd1;
          if (rsp_err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q        <= S_IDLE;
      last_q         <= IDW'(NUM_REQ - 1);
      gnt_q          <= '0;
      conv_code_in_q <= '0;
      conv_select_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_code_q     <= '0;
      rsp_err_q      <= 1'b0;
      done_count_q   <= '0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      gnt_q          <= gnt_d;
      conv_code_in_q <= conv_code_in_d;
      conv_select_q  <= conv_select_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_code_q     <= rsp_code_d;
      rsp_err_q      <= rsp_err_d;
      done_count_q   <= done_count_d;
      err_count_q    <= err_count_d;
    end
  end

  assign gnt          = gnt_q;
  assign conv_code_in = conv_code_in_q;
  assign conv_select  = conv_select_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_code     = rsp_code_q;
  assign rsp_err      = rsp_err_q;
  assign done_count   = done_count_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Directed bench for code_conv_arbiter; the bench also plays the shared converter.
module tb_code_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_code;
  logic [7:0]  req_sel;
  logic [3:0]  gnt;
  logic [3:0]  conv_code_in;
  logic [1:0]  conv_select;
  logic [3:0]  conv_code_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_code;
  logic        rsp_err;
  logic [7:0]  done_count;
  logic [7:0]  err_count;

  int vectors = 0;
  int miscompares = 0;

  logic       got_valid;
  logic [1:0] got_id;
  logic [3:0] got_code;
  logic       got_err;

  always #5 clk = ~clk;

  code_conv_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_code(req_code), .req_sel(req_sel),
    .gnt(gnt), .conv_code_in(conv_code_in), .conv_select(conv_select),
    .conv_code_out(conv_code_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_code(rsp_code), .rsp_err(rsp_err),
    .done_count(done_count), .err_count(err_count)
  );

  function automatic logic [3:0] conv_model(input logic [3:0] c, input logic [1:0] s);
    logic [3:0] b;
    case (s)
      2'b00: b = c ^ (c >> 1);
      2'b01: b = c + 4'd3;
      2'b10: begin
        b[3] = c[3];
        b[2] = b[3] ^ c[2];
        b[1] = b[2] ^ c[1];
        b[0] = b[1] ^ c[0];
      end
      default: b = c - 4'd3;
    endcase
    return b;
  endfunction

  function automatic logic err_model(input logic [3:0] c, input logic [1:0] s);
    if (s == 2'b01) return c > 4'd9;
    if (s == 2'b11) return (c < 4'd3) || (c > 4'd12);
    return 1'b0;
  endfunction

  assign conv_code_out = conv_model(conv_code_in, conv_select);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction with rsp_ready=1; waits are bounded and the result is
  // left in got_* for the caller (got_valid=0 means it never completed).
  task automatic run_one(input int id, input logic [3:0] code, input logic [1:0] sel);
    int n;
    req_code[4*id +: 4] = code;
    req_sel[2*id +: 2]  = sel;
    req[id]   = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (gnt === 4'b0000 && n < 8);
    req[id] = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 8) begin tick(); n++; end
    got_valid = rsp_valid;
    got_id    = rsp_id;
    got_code  = rsp_code;
    got_err   = rsp_err;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    vectors++; if ({rsp_valid, rsp_id, rsp_code, rsp_err} !== 8'h00) begin miscompares++;
      $display("FAIL reset_rsp: got valid=%b id=%0d code=%b err=%b expected all 0", rsp_valid, rsp_id, rsp_code, rsp_err); end
    vectors++; if ({conv_code_in, conv_select} !== 6'h00) begin miscompares++;
      $display("FAIL reset_conv: got code=%b sel=%b expected 0", conv_code_in, conv_select); end
    vectors++; if ({done_count, err_count} !== 16'h0000) begin miscompares++;
      $display("FAIL reset_counts: got done=%0d err=%0d expected 0", done_count, err_count); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_code[11:8] = 4'b0101;
    req_sel[5:4]   = 2'b00;
    req            = 4'b0100;
    rsp_ready      = 1'b1;
    tick();
    vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt: got %b expected 0100", gnt); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid); end
    vectors++; if ({conv_code_in, conv_select} !== 6'b0101_00) begin miscompares++;
      $display("FAIL single_conv_drive: got %b/%b expected 0101/00", conv_code_in, conv_select); end
    req = 4'b0000;
    tick();
    vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL single_gnt_pulse: got %b expected 0000", gnt); end
    vectors++; if ({rsp_valid, rsp_id, rsp_code, rsp_err} !== {1'b1, 2'd2, 4'b0111, 1'b0}) begin miscompares++;
      $display("FAIL single_rsp: got valid=%b id=%0d code=%b err=%b expected 1/2/0111/0", rsp_valid, rsp_id, rsp_code, rsp_err); end
    tick();
    vectors++; if (done_count !== 8'd1) begin miscompares++; $display("FAIL single_done: got %0d expected 1", done_count); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_fairness();
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] exp_gnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_code  = 16'h4321;
    req_sel   = 8'h00;
    req       = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = 4'b0001 << exp_order[k];
      tick();
      vectors++; if (gnt !== exp_gnt) begin miscompares++;
        $display("FAIL fair_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
      tick();
      vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_order[k]) || gnt !== 4'b0000) begin miscompares++;
        $display("FAIL fair_rsp[%0d]: got valid=%b id=%0d gnt=%b expected 1/%0d/0000", k, rsp_valid, rsp_id, gnt, exp_order[k]); end
      tick();
      vectors++; if (gnt !== 4'b0000 || rsp_valid !== 1'b0) begin miscompares++;
        $display("FAIL fair_idle[%0d]: got gnt=%b valid=%b expected 0000/0", k, gnt, rsp_valid); end
    end
    req = 4'b0000;
    vectors++; if (done_count !== 8'd6) begin miscompares++; $display("FAIL fair_done: got %0d expected 6", done_count); end
  endtask

  task automatic test_backpressure();
    req_code[15:12] = 4'b0011;
    req_sel[7:6]    = 2'b00;
    req             = 4'b1000;
    rsp_ready       = 1'b0;
    tick();
    vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("FAIL bp_gnt: got %b expected 1000", gnt); end
    req           = 4'b0010;
    req_code[7:4] = 4'b1111;
    tick();
    for (int k = 0; k < 6; k++) begin
      vectors++; if ({rsp_valid, rsp_id, rsp_code, rsp_err, gnt} !== {1'b1, 2'd3, 4'b0010, 1'b0, 4'b0000}) begin miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%b id=%0d code=%b err=%b gnt=%b expected 1/3/0010/0/0000",
                 k, rsp_valid, rsp_id, rsp_code, rsp_err, gnt); end
      if (k < 5) tick();
    end
    req       = 4'b0011;
    rsp_ready = 1'b1;
    tick();
    vectors++; if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin miscompares++;
      $display("FAIL bp_release: got valid=%b gnt=%b expected 0/0000", rsp_valid, gnt); end
    tick();
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL bp_next_gnt: got %b expected 0001", gnt); end
    req = 4'b0000;
    tick();
    tick();
    vectors++; if (done_count !== 8'd8) begin miscompares++; $display("FAIL bp_done: got %0d expected 8", done_count); end
  endtask

  task automatic test_errors();
    run_one(0, 4'b1010, 2'b01);
    vectors++; if ({got_valid, got_code, got_err} !== {1'b1, 4'b1101, 1'b1}) begin miscompares++;
      $display("FAIL err_bcd_1010: got valid=%b code=%b err=%b expected 1/1101/1", got_valid, got_code, got_err); end
    run_one(0, 4'b0010, 2'b11);
    vectors++; if ({got_valid, got_code, got_err} !== {1'b1, 4'b1111, 1'b1}) begin miscompares++;
      $display("FAIL err_xs3_0010: got valid=%b code=%b err=%b expected 1/1111/1", got_valid, got_code, got_err); end
    run_one(0, 4'b1010, 2'b11);
    vectors++; if ({got_valid, got_code, got_err} !== {1'b1, 4'b0111, 1'b0}) begin miscompares++;
      $display("FAIL err_xs3_1010: got valid=%b code=%b err=%b expected 1/0111/0", got_valid, got_code, got_err); end
    vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL err_count_2: got %0d expected 2", err_count); end
    for (int k = 0; k < 258; k++) begin
      run_one(0, 4'b1111, 2'b01);
      vectors++; if (got_valid !== 1'b1 || got_err !== 1'b1) begin miscompares++;
        $display("FAIL err_loop[%0d]: got valid=%b err=%b expected 1/1", k, got_valid, got_err); end
    end
    vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL err_count_sat: got %0d expected 255", err_count); end
    vectors++; if (done_count !== 8'd13) begin miscompares++; $display("FAIL done_wrap: got %0d expected 13", done_count); end
  endtask

  task automatic test_reset_mid();
    req_code  = 16'hAAAA;
    req_sel   = 8'h55;
    req       = 4'b1111;
    rsp_ready = 1'b0;
    tick();
    vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL rmid_gnt: got %b expected 0010", gnt); end
    tick();
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin miscompares++;
      $display("FAIL rmid_valid: got valid=%b err=%b expected 1/1", rsp_valid, rsp_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if ({gnt, rsp_valid, rsp_id, rsp_code, rsp_err, conv_code_in, conv_select, done_count, err_count} !== 34'd0) begin
      miscompares++;
      $display("FAIL rmid_outputs: got gnt=%b valid=%b id=%0d code=%b err=%b cin=%b csel=%b done=%0d errc=%0d expected all 0",
               gnt, rsp_valid, rsp_id, rsp_code, rsp_err, conv_code_in, conv_select, done_count, err_count); end
    rsp_ready = 1'b1;
    tick();
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL rmid_first_gnt: got %b expected 0001", gnt); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_exhaustive();
    logic [3:0] c;
    logic [1:0] s;
    req_code = 16'h0000;
    req_sel  = 8'h00;
    run_one(3, 4'b0111, 2'b10);
    vectors++; if (got_code !== 4'b0101) begin miscompares++; $display("FAIL exh_gray_0111: got %b expected 0101", got_code); end
    run_one(3, 4'b0111, 2'b01);
    vectors++; if (got_code !== 4'b1010) begin miscompares++; $display("FAIL exh_bcd_0111: got %b expected 1010", got_code); end
    for (int si = 0; si < 4; si++) begin
      for (int ci = 0; ci < 16; ci++) begin
        s = si[1:0];
        c = ci[3:0];
        run_one(3, c, s);
        vectors++;
        if (got_valid !== 1'b1 || got_id !== 2'd3 || got_code !== conv_model(c, s) || got_err !== err_model(c, s)) begin
          miscompares++;
          $display("FAIL exh sel=%b code=%b: got valid=%b id=%0d code=%b err=%b expected 1/3/%b/%b",
                   s, c, got_valid, got_id, got_code, got_err, conv_model(c, s), err_model(c, s));
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_code  = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
